// File: rtl/issue_sequencer.sv
// Fetch/issue controller: walks instruction memory from START_ADDR, issues one word per cycle
// to decode, and inserts bubbles while a source register is still being produced in EX or MEM.
module issue_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int START_ADDR   = 0,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   prog_len,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_q,
  output logic                  issue_valid,
  output logic [31:0]           issue_instr,
  output logic [ADDR_WIDTH-1:0] issue_pc,
  output logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bubble_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] START      = ADDR_WIDTH'(START_ADDR);
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t                r_state, w_next_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH:0]   r_remaining;
  logic [DW-1:0]         r_drain_cnt;
  logic                  r_ex_v, r_mem_v;
  logic [4:0]            r_ex_dest, r_mem_dest;
  logic [15:0]           r_bubble_count;

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd, w_dest;
  logic       w_is_r, w_is_lw, w_is_sw;
  logic       w_src_rs, w_src_rt, w_has_dest;
  logic       w_rs_busy, w_rt_busy, w_hazard, w_accept;

  assign w_op = imem_q[31:26];
  assign w_rs = imem_q[25:21];
  assign w_rt = imem_q[20:16];
  assign w_rd = imem_q[15:11];

  assign w_is_r     = (w_op == 6'b010010);
  assign w_is_lw    = (w_op == 6'b010011);
  assign w_is_sw    = (w_op == 6'b010100);
  assign w_src_rs   = w_is_r || w_is_lw || w_is_sw;
  assign w_src_rt   = w_is_r || w_is_sw;
  assign w_has_dest = w_is_r || w_is_lw;
  assign w_dest     = w_is_r ? w_rd : w_rt;

  // A producer in WB is already visible to the register-file read, so only EX and MEM matter.
  assign w_rs_busy = (r_ex_v && (w_rs == r_ex_dest)) || (r_mem_v && (w_rs == r_mem_dest));
  assign w_rt_busy = (r_ex_v && (w_rt == r_ex_dest)) || (r_mem_v && (w_rt == r_mem_dest));
  assign w_hazard  = (w_src_rs && w_rs_busy) || (w_src_rt && w_rt_busy);
  assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE:
        if (w_accept) w_next_state = (prog_len == '0) ? S_DRAIN : S_RUN;
      S_RUN:
        if (!w_hazard && (r_remaining == (ADDR_WIDTH+1)'(1))) w_next_state = S_DRAIN;
      S_DRAIN:
        if (r_drain_cnt == DRAIN_LAST) w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_pc    = '0;
    stall       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    imem_addr   = START;
    unique case (r_state)
      S_RUN: begin
        busy        = 1'b1;
        issue_valid = !w_hazard;
        stall       = w_hazard;
        // A stalled candidate is re-read so it is still on imem_q next cycle.
        imem_addr   = w_hazard ? r_cur_addr : r_cur_addr + 1'b1;
        if (!w_hazard) begin
          issue_instr = imem_q;
          issue_pc    = r_cur_addr;
        end
      end
      S_DRAIN: begin
        busy      = 1'b1;
        imem_addr = r_cur_addr;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr     <= '0;
      r_remaining    <= '0;
      r_drain_cnt    <= '0;
      r_ex_v         <= 1'b0;
      r_ex_dest      <= '0;
      r_mem_v        <= 1'b0;
      r_mem_dest     <= '0;
      r_bubble_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_ex_v      <= issue_valid && w_has_dest;
      r_ex_dest   <= w_dest;
      r_mem_v     <= r_ex_v;
      r_mem_dest  <= r_ex_dest;
      r_drain_cnt <= ((r_state == S_DRAIN) && (w_next_state == S_DRAIN)) ? r_drain_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_cur_addr     <= START;
        r_remaining    <= prog_len;
        r_bubble_count <= '0;
      end else begin
        if (issue_valid) begin
          r_cur_addr  <= r_cur_addr + 1'b1;
          r_remaining <= r_remaining - 1'b1;
        end
        if (stall && (r_bubble_count != 16'hFFFF)) r_bubble_count <= r_bubble_count + 1'b1;
      end
    end
  end

  assign bubble_count = r_bubble_count;

endmodule

// File: tb/tb_issue_sequencer.sv
// Bench for issue_sequencer: directed and random programs checked cycle by cycle against an
// issue schedule derived from the producer/consumer distance rule.
module tb_issue_sequencer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic          issue_valid;
  logic [31:0]   issue_instr;
  logic [AW-1:0] issue_pc;
  logic          stall, busy, done;
  logic [15:0]   bubble_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:(1<<AW)-1];
  logic [31:0] prog [0:63];
  int          sched [0:63];
  int          t_last;

  issue_sequencer #(.ADDR_WIDTH(AW), .START_ADDR(0), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_q(imem_q),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_pc(issue_pc),
    .stall(stall), .busy(busy), .done(done), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_q <= mem[imem_addr];

  task automatic check(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt);
    return {6'b010010, 5'(rs), 5'(rt), 5'(rd), 11'h020};
  endfunction
  function automatic logic [31:0] enc_lw(input int rt, input int rs);
    return {6'b010011, 5'(rs), 5'(rt), 16'h0004};
  endfunction
  function automatic logic [31:0] enc_sw(input int rt, input int rs);
    return {6'b010100, 5'(rs), 5'(rt), 16'h0008};
  endfunction
  function automatic logic [31:0] enc_unk(input int r);
    return {6'b111111, 5'(r), 5'(r), 5'(r), 11'h000};
  endfunction

  function automatic bit tb_writes(input logic [31:0] w);
    return (w[31:26] == 6'b010010) || (w[31:26] == 6'b010011);
  endfunction
  function automatic int tb_dest(input logic [31:0] w);
    return (w[31:26] == 6'b010010) ? int'(w[15:11]) : int'(w[20:16]);
  endfunction
  function automatic bit tb_reads(input logic [31:0] w, input int r);
    case (w[31:26])
      6'b010010, 6'b010100: return (int'(w[25:21]) == r) || (int'(w[20:16]) == r);
      6'b010011:            return int'(w[25:21]) == r;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    int k = int'($urandom_range(0, 3));
    int a = int'($urandom_range(0, 3));
    int b = int'($urandom_range(0, 3));
    int d = int'($urandom_range(0, 3));
    case (k)
      0:       return enc_r(d, a, b);
      1:       return enc_lw(d, a);
      2:       return enc_sw(a, b);
      default: return {($urandom_range(0, 1) == 0) ? 6'b000000 : 6'b111111, 26'($urandom)};
    endcase
  endfunction

  // A result issued at cycle t sits in EX at t+1, MEM at t+2 and WB at t+3, so a reader may
  // issue no earlier than t+3; otherwise one instruction issues per cycle.
  function automatic void build_model(input int n);
    int prev = 0;
    for (int i = 0; i < n; i++) begin
      int e = prev + 1;
      for (int j = 0; j < i; j++)
        if (tb_writes(prog[j]) && tb_reads(prog[i], tb_dest(prog[j])) && (sched[j] + 3 > e))
          e = sched[j] + 3;
      sched[i] = e;
      prev = e;
    end
    t_last = prev;
  endfunction

  task automatic run_prog(input string name, input int n, input int inject_c, input int abort_c);
    build_model(n);
    for (int i = 0; i < n; i++) mem[i] = prog[i];
    @(negedge clk);
    prog_len = (AW+1)'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    prog_len = (AW+1)'($urandom);
    for (int c = 1; c <= t_last + 6; c++) begin
      logic ev;
      int   epc, issued;
      if (c > 1) @(negedge clk);
      if (c == abort_c) begin
        rst_n = 1'b0;
        #1;
        check({name, ".rst_valid"}, c, 32'(issue_valid), 32'd0);
        check({name, ".rst_stall"}, c, 32'(stall), 32'd0);
        check({name, ".rst_busy"},  c, 32'(busy), 32'd0);
        check({name, ".rst_done"},  c, 32'(done), 32'd0);
        check({name, ".rst_addr"},  c, 32'(imem_addr), 32'd0);
        check({name, ".rst_bub"},   c, 32'(bubble_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      ev = 1'b0;
      epc = 0;
      issued = 0;
      for (int i = 0; i < n; i++) begin
        if (sched[i] == c) begin ev = 1'b1; epc = i; end
        if (sched[i] <= c) issued++;
      end
      check({name, ".valid"}, c, 32'(issue_valid), 32'(ev));
      check({name, ".pc"},    c, 32'(issue_pc), ev ? 32'(epc) : 32'd0);
      check({name, ".instr"}, c, issue_instr, ev ? prog[epc] : 32'd0);
      check({name, ".stall"}, c, 32'(stall), 32'((c <= t_last) && !ev));
      check({name, ".busy"},  c, 32'(busy), 32'(c <= t_last + 3));
      check({name, ".done"},  c, 32'(done), 32'(c >= t_last + 4));
      if (c <= t_last) check({name, ".addr"}, c, 32'(imem_addr), 32'(issued));
      start = (c == inject_c);
    end
    start = 1'b0;
    check({name, ".bubbles"}, t_last + 6, 32'(bubble_count), 32'(t_last - n));
  endtask

  task automatic load_hazard_prog();
    for (int k = 0; k < 4; k++) prog[k] = enc_lw(k, 9);
    prog[4] = enc_r(4, 0, 1);
    prog[5] = enc_r(5, 2, 3);
    prog[6] = enc_r(6, 4, 5);
    prog[7] = enc_sw(6, 9);
  endtask

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset.valid", 0, 32'(issue_valid), 32'd0);
    check("reset.stall", 0, 32'(stall), 32'd0);
    check("reset.busy",  0, 32'(busy), 32'd0);
    check("reset.done",  0, 32'(done), 32'd0);
    check("reset.instr", 0, issue_instr, 32'd0);
    check("reset.pc",    0, 32'(issue_pc), 32'd0);
    check("reset.addr",  0, 32'(imem_addr), 32'd0);
    check("reset.bub",   0, 32'(bubble_count), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    load_hazard_prog();
    run_prog("hazard", 8, 0, 0);
    check("hazard.bub5", 0, 32'(bubble_count), 32'd5);

    for (int k = 0; k < 8; k++) prog[k] = enc_r(16 + k, 1, 2);
    run_prog("indep", 8, 0, 0);

    prog[0] = enc_lw(7, 9);
    prog[1] = enc_r(2, 7, 1);
    run_prog("lw_use", 2, 0, 0);

    prog[0] = enc_lw(5, 9);
    prog[1] = enc_unk(5);
    prog[2] = enc_unk(1);
    prog[3] = enc_r(6, 1, 1);
    prog[4] = enc_unk(6);
    run_prog("unknown", 5, 0, 0);

    load_hazard_prog();
    run_prog("abort", 8, 0, 6);
    run_prog("rerun", 8, 0, 0);

    run_prog("empty", 0, 2, 0);

    for (int r = 0; r < 8; r++) begin
      int n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) prog[i] = rand_instr();
      run_prog($sformatf("rand%0d", r), n, (r == 2) ? 3 : 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
